// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The unit connects through the slave modport; control unit plus memory use master.
interface load_store_unit_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_func3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_wr;
    logic [63:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wr
    );

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer for a 64-bit doubleword data memory: extends loads,
// performs sub-doubleword stores by read-modify-write, rejects illegal/misaligned requests.
module load_store_unit #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    load_store_unit_if.slave      bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        func3_q, func3_d;
    logic [2:0]        off_q, off_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              req_illegal;
    logic              req_misaligned;

    function automatic logic [63:0] extract(input logic [63:0] word, input logic [2:0] off,
                                            input logic [2:0] f3);
        logic [63:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{56{sh[7]}},  sh[7:0]};
            3'b001:  extract = {{48{sh[15]}}, sh[15:0]};
            3'b010:  extract = {{32{sh[31]}}, sh[31:0]};
            3'b100:  extract = {56'b0, sh[7:0]};
            3'b101:  extract = {48'b0, sh[15:0]};
            3'b110:  extract = {32'b0, sh[31:0]};
            default: extract = sh;
        endcase
    endfunction

    // Byte lanes off..off+size-1 come from the store data, the rest from the read word.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [2:0] off, input logic [1:0] sz_log);
        logic [63:0] mask;
        case (sz_log)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = '1;
        endcase
        mask  = mask << {off, 3'b000};
        merge = (old & ~mask) | ((wd << {off, 3'b000}) & mask);
    endfunction

    always_comb begin
        req_illegal = bus.req_we ? bus.req_func3[2] : (bus.req_func3 == 3'b111);
        case (bus.req_func3[1:0])
            2'b01:   req_misaligned = bus.req_addr[0];
            2'b10:   req_misaligned = |bus.req_addr[1:0];
            2'b11:   req_misaligned = |bus.req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        func3_d      = func3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    func3_d    = bus.req_func3;
                    off_d      = bus.req_addr[2:0];
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = {bus.req_addr[ADDR_W-1:3], 3'b000};
                    if (req_illegal || req_misaligned) begin
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else if (bus.req_we && bus.req_func3[1:0] == 2'b11) begin
                        mem_wdata_d = bus.req_wdata;
                        state_d     = WRITE;
                    end else begin
                        cnt_d   = CNT_W'(MEM_LAT);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (we_q) begin
                        mem_wdata_d = merge(bus.mem_rdata, wdata_q, off_q, func3_q[1:0]);
                        state_d     = WRITE;
                    end else begin
                        resp_rdata_d = extract(bus.mem_rdata, off_q, func3_q);
                        resp_err_d   = 1'b0;
                        state_d      = RESP;
                    end
                end
            end
            WRITE: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            func3_q      <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            func3_q      <= func3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.mem_wr     = (state_q == WRITE);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LAT 1 and 3) share one memory and a
// byte-array reference model; directed cases followed by random requests.
module tb_load_store_unit;
    logic clk;
    logic reset;
    logic sel;
    logic req_valid, req_we;
    logic [2:0]  req_func3;
    logic [63:0] req_addr, req_wdata;

    logic [63:0] mem [32];
    logic [7:0]  ref_bytes [256];
    logic        pre_we;
    logic [4:0]  pre_idx;
    logic [63:0] pre_val;
    logic [63:0] p1, p2;

    logic        ready_m, rv_m, err_m, mw_m;
    logic [63:0] rd_m, wd_m, ma_m;

    int unsigned n_checks;
    int unsigned n_errors;

    load_store_unit_if #(.ADDR_W(64)) if1 ();
    load_store_unit_if #(.ADDR_W(64)) if3 ();

    load_store_unit #(.MEM_LAT(1), .ADDR_W(64)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    load_store_unit #(.MEM_LAT(3), .ADDR_W(64)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign if1.req_valid = req_valid & ~sel;
    assign if3.req_valid = req_valid & sel;
    assign if1.req_we    = req_we;
    assign if3.req_we    = req_we;
    assign if1.req_func3 = req_func3;
    assign if3.req_func3 = req_func3;
    assign if1.req_addr  = req_addr;
    assign if3.req_addr  = req_addr;
    assign if1.req_wdata = req_wdata;
    assign if3.req_wdata = req_wdata;

    assign if1.mem_rdata = mem[if1.mem_addr[7:3]];
    assign if3.mem_rdata = p2;

    assign ready_m = sel ? if3.req_ready  : if1.req_ready;
    assign rv_m    = sel ? if3.resp_valid : if1.resp_valid;
    assign err_m   = sel ? if3.resp_err   : if1.resp_err;
    assign rd_m    = sel ? if3.resp_rdata : if1.resp_rdata;
    assign mw_m    = sel ? if3.mem_wr     : if1.mem_wr;
    assign wd_m    = sel ? if3.mem_wdata  : if1.mem_wdata;
    assign ma_m    = sel ? if3.mem_addr   : if1.mem_addr;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mw_m) mem[ma_m[7:3]] <= wd_m;
        p1 <= mem[if3.mem_addr[7:3]];
        p2 <= p1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_dw(input int unsigned idx, input logic [63:0] v);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = idx[4:0];
        pre_val = v;
        for (int unsigned b = 0; b < 8; b++) ref_bytes[idx*8 + b] = v[b*8 +: 8];
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    function automatic logic [63:0] ref_dw(input logic [7:0] a);
        logic [63:0] v;
        int unsigned base;
        base = int'(a) & 32'hF8;
        for (int unsigned b = 0; b < 8; b++) v[b*8 +: 8] = ref_bytes[base + b];
        return v;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [7:0] a);
        logic [63:0] v;
        int unsigned sz;
        sz = 1 << f3[1:0];
        v  = 0;
        for (int unsigned b = 0; b < sz; b++) v = v + (64'(ref_bytes[int'(a) + b]) << (8*b));
        if (sz < 8 && !f3[2] && v[8*sz-1]) v = v - (64'd1 << (8*sz));
        return v;
    endfunction

    task automatic do_req(input bit s, input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [63:0] wd, input bit hold, output logic [63:0] rd);
        int unsigned lat, sz, exp_k, exp_wk, wr_n, wr_k, k;
        bit ok, got;
        logic [63:0] exp_rd, exp_wd, obs_wd, obs_rd;
        logic obs_err;
        lat = s ? 3 : 1;
        sz  = 1 << f3[1:0];
        ok  = (we ? (f3 < 3'd4) : (f3 != 3'd7)) && ((int'(a) % sz) == 0);
        exp_rd = 0; exp_wd = 0; exp_wk = 0;
        if (!ok) exp_k = 1;
        else if (!we) begin
            exp_k  = lat + 1;
            exp_rd = ref_load(f3, a);
        end else begin
            for (int unsigned b = 0; b < sz; b++) ref_bytes[int'(a) + b] = wd[b*8 +: 8];
            exp_wd = ref_dw(a);
            exp_k  = (sz == 8) ? 2 : lat + 2;
            exp_wk = (sz == 8) ? 1 : lat + 1;
        end
        @(negedge clk);
        sel = s; req_valid = 1'b1; req_we = we; req_func3 = f3;
        req_addr = {56'b0, a}; req_wdata = wd;
        #1 check("req_ready", ready_m, 1);
        @(posedge clk);
        got = 0; wr_n = 0; wr_k = 0; obs_wd = 0; obs_rd = 0; obs_err = 0; k = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (!hold) req_valid = 1'b0;
            check("mem_addr", ma_m, {56'b0, a & 8'hF8});
            if (mw_m) begin
                wr_n++;
                wr_k   = k;
                obs_wd = wd_m;
            end
            if (rv_m) begin
                got     = 1;
                obs_rd  = rd_m;
                obs_err = err_m;
            end else check("busy_ready", ready_m, 0);
        end
        req_valid = 1'b0;
        check("resp_seen", got, 1);
        check("latency", k, exp_k);
        check("rdata", obs_rd, exp_rd);
        check("err", obs_err, !ok);
        check("wr_count", wr_n, (exp_wk != 0) ? 1 : 0);
        if (exp_wk != 0) begin
            check("wr_cycle", wr_k, exp_wk);
            check("wdata", obs_wd, exp_wd);
        end
        rd = obs_rd;
    endtask

    initial begin
        logic [63:0] rd;
        int unsigned wr_seen;
        logic [2:0] f3;
        logic [7:0] a;
        logic we;
        n_checks = 0; n_errors = 0;
        reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_func3 = '0; req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready1", if1.req_ready, 1);
        check("rst_rv1", if1.resp_valid, 0);
        check("rst_rdata1", if1.resp_rdata, 0);
        check("rst_err1", if1.resp_err, 0);
        check("rst_maddr1", if1.mem_addr, 0);
        check("rst_mwdata1", if1.mem_wdata, 0);
        check("rst_mwr1", if1.mem_wr, 0);
        check("rst_ready3", if3.req_ready, 1);
        check("rst_rv3", if3.resp_valid, 0);
        for (int unsigned i = 0; i < 32; i++) set_dw(i, {$urandom, $urandom});
        set_dw(2, 64'h8877665544332211);
        @(negedge clk);
        reset = 1'b1;

        do_req(0, 0, 3'b000, 8'h17, 64'h0, 0, rd); check("t1_lb", rd, 64'hFFFFFFFFFFFFFF88);
        do_req(0, 0, 3'b101, 8'h16, 64'h0, 0, rd); check("t2_lhu", rd, 64'h0000000000008877);
        do_req(0, 0, 3'b010, 8'h14, 64'h0, 1, rd); check("t2_lw", rd, 64'hFFFFFFFF88776655);
        do_req(0, 0, 3'b011, 8'h10, 64'h0, 0, rd); check("t2_ld", rd, 64'h8877665544332211);
        do_req(0, 1, 3'b000, 8'h13, 64'hAB, 0, rd);
        check("t3_mem", mem[2], 64'h88776655AB332211);
        do_req(0, 1, 3'b011, 8'h18, 64'h0123456789ABCDEF, 0, rd);
        check("t4_mem", mem[3], 64'h0123456789ABCDEF);
        do_req(0, 0, 3'b010, 8'h12, 64'h0, 0, rd); check("t5_lw_mis", rd, 0);
        do_req(0, 1, 3'b001, 8'h11, 64'h55, 1, rd); check("t5_sh_mis", rd, 0);
        do_req(0, 0, 3'b111, 8'h10, 64'h0, 0, rd); check("t5_ill", rd, 0);

        // Reset mid read-modify-write: the pending write must never reach memory.
        @(negedge clk);
        sel = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b001;
        req_addr = 64'h22; req_wdata = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t6_busy", ready_m, 0);
        reset = 1'b0;
        #1;
        check("t6_ready", ready_m, 1);
        check("t6_mwr", mw_m, 0);
        check("t6_rv", rv_m, 0);
        wr_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (mw_m) wr_seen++;
        end
        check("t6_nowrite", wr_seen, 0);
        reset = 1'b1;
        check("t6_mem", mem[4], ref_dw(8'h20));
        do_req(1, 0, 3'b000, 8'h17, 64'h0, 1, rd); check("t6_lb_lat3", rd, 64'hFFFFFFFFFFFFFF88);

        for (int unsigned n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << f3[1:0]) - 1);
            do_req(1'($urandom_range(0, 1)), we, f3, a, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), rd);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        @(negedge clk);
        for (int unsigned i = 0; i < 32; i++) check("final_mem", mem[i], ref_dw(8'(i*8)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
